// File: rtl/plasma_de1_soc_sys_pll_reset_seq_pkg.sv
// Shared types and default timing constants for the Plasma DE1-SoC PLL reset sequencer.
package plasma_sys_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_POWERUP   = 3'd3,
    S_RUN       = 3'd4
  } pll_seq_state_t;

  // Defaults are refclk (50 MHz) cycle counts.
  localparam int unsigned PLL_RST_CYCLES_DEF      = 16;
  localparam int unsigned LOCK_STABLE_CYCLES_DEF  = 1024;
  localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 65536;
  localparam int unsigned SDRAM_INIT_CYCLES_DEF   = 5000;
  localparam int unsigned CNT_W_DEF               = 17;

  localparam int unsigned RELOCK_W = 8;

  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/plasma_de1_soc_sys_pll_reset_seq_if.sv
// PLL / system-reset signal bundle between the sequencer (master) and the rest of the system.
interface plasma_de1_soc_sys_pll_reset_seq_if;
  import plasma_sys_pkg::*;

  logic                pll_locked;
  logic                pll_rst;
  logic                sys_reset_n;
  logic                sdram_init_start;
  logic                ready;
  logic [RELOCK_W-1:0] relock_count;
  logic                timeout_err;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_reset_n,
    output sdram_init_start,
    output ready,
    output relock_count,
    output timeout_err
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_reset_n,
    input  sdram_init_start,
    input  ready,
    input  relock_count,
    input  timeout_err
  );

endinterface

// File: rtl/plasma_de1_soc_sys_pll_reset_seq_sync.sv
// Two-flop synchronizer for a single asynchronous level; both stages reset to 0.
module plasma_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/plasma_de1_soc_sys_pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, holds system reset through
// SDRAM power-up, and re-sequences on lock loss or lock timeout. Runs on refclk only.
module plasma_de1_soc_sys_pll_reset_seq
  import plasma_sys_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
  parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int unsigned SDRAM_INIT_CYCLES   = SDRAM_INIT_CYCLES_DEF,
  parameter int unsigned CNT_W               = CNT_W_DEF
) (
  input  logic refclk,
  input  logic rst_n,
  plasma_de1_soc_sys_pll_reset_seq_if.master bus
);

  localparam logic [CNT_W-1:0] PLL_RST_LOAD = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POWERUP_LOAD = CNT_W'(SDRAM_INIT_CYCLES - 1);

  pll_seq_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cnt_exp;
  logic                lock_s;
  logic                timeout_hit;
  logic                lock_lost_run;

  logic                pll_rst_q;
  logic                sys_reset_n_q;
  logic                sdram_init_start_q;
  logic                ready_q;
  logic [RELOCK_W-1:0] relock_count_q;
  logic                timeout_err_q;

  plasma_sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (lock_s)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PLL_RST;
      cnt_q   <= PLL_RST_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_exp       = (cnt_q == '0);
    timeout_hit   = 1'b0;
    lock_lost_run = 1'b0;

    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_exp) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock arriving on the last timeout cycle still wins.
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_exp) begin
          state_d     = S_PLL_RST;
          timeout_hit = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s)      state_d = S_WAIT_LOCK;
        else if (cnt_exp) state_d = S_POWERUP;
      end
      S_POWERUP: begin
        if (!lock_s)      state_d = S_PLL_RST;
        else if (cnt_exp) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d       = S_PLL_RST;
          lock_lost_run = 1'b1;
        end
      end
      default: state_d = S_PLL_RST;
    endcase

    // Every state change reloads the shared counter for the state being entered.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      unique case (state_d)
        S_PLL_RST:   cnt_d = PLL_RST_LOAD;
        S_WAIT_LOCK: cnt_d = TIMEOUT_LOAD;
        S_STABLE:    cnt_d = STABLE_LOAD;
        S_POWERUP:   cnt_d = POWERUP_LOAD;
        default:     cnt_d = '0;
      endcase
    end else if (!cnt_exp) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q          <= 1'b1;
      sys_reset_n_q      <= 1'b0;
      sdram_init_start_q <= 1'b0;
      ready_q            <= 1'b0;
      relock_count_q     <= '0;
      timeout_err_q      <= 1'b0;
    end else begin
      pll_rst_q          <= (state_d == S_PLL_RST);
      sys_reset_n_q      <= (state_d == S_RUN);
      ready_q            <= (state_d == S_RUN);
      sdram_init_start_q <= (state_d == S_RUN) && (state_q != S_RUN);
      if (lock_lost_run) relock_count_q <= sat_inc(relock_count_q);
      if (timeout_hit)   timeout_err_q  <= 1'b1;
    end
  end

  assign bus.pll_rst          = pll_rst_q;
  assign bus.sys_reset_n      = sys_reset_n_q;
  assign bus.sdram_init_start = sdram_init_start_q;
  assign bus.ready            = ready_q;
  assign bus.relock_count     = relock_count_q;
  assign bus.timeout_err      = timeout_err_q;

endmodule

// File: doc/plasma_de1_soc_sys_pll_reset_seq.md
# plasma_de1_soc_sys_pll_reset_seq

Reset sequencer between the SDRAM/system PLL and the rest of the DE1-SoC Plasma system. It drives the PLL reset, watches the PLL `locked` output, and releases system reset only after lock has held steady and the SDRAM power-up delay has elapsed. It re-sequences on any loss of lock or lock timeout and keeps diagnostic counters. It runs on the 50 MHz board reference clock, so it keeps working while the PLL outputs are invalid.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16 — cycles `pll_rst` is held high per PLL reset pulse
- `LOCK_STABLE_CYCLES`, 1024 — consecutive synced-lock cycles required before lock is accepted
- `LOCK_TIMEOUT_CYCLES`, 65536 — maximum cycles spent waiting for first lock assertion
- `SDRAM_INIT_CYCLES`, 5000 — power-up hold after accepted lock (100 µs at 50 MHz)
- `CNT_W`, 17 — shared counter width; must hold the largest of the four cycle parameters

Ports:
- `refclk` input 1 — 50 MHz board clock, the only clock
- `rst_n` input 1 — asynchronous, active-low reset
- `pll_locked` input 1 — PLL `locked`, asynchronous to `refclk`
- `pll_rst` output 1 — active-high reset to the PLL
- `sys_reset_n` output 1 — active-low system/SDRAM-controller reset, `refclk` domain
- `sdram_init_start` output 1 — one-cycle pulse on system release
- `ready` output 1 — high while in RUN
- `relock_count` output 8 — number of lock losses seen in RUN; saturates at 255
- `timeout_err` output 1 — sticky; set on any lock timeout

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `lock_s`. The FSM uses only `lock_s`.
- FSM states: PLL_RST, WAIT_LOCK, STABLE, POWERUP, RUN.
- One down-counter `cnt` is shared by all states. It is loaded with (parameter − 1) on each state entry. "Expires" means `cnt`==0 while the state condition still holds.
- PLL_RST: `pll_rst`=1. When `cnt` expires, go to WAIT_LOCK.
- WAIT_LOCK:
  - `lock_s`=1 → STABLE.
  - Otherwise, on expiry → PLL_RST and set `timeout_err`.
  - `lock_s` has priority over expiry in the same cycle.
- STABLE:
  - `lock_s`=0 → WAIT_LOCK, with the timeout counter reloaded.
  - Expiry with `lock_s`=1 → POWERUP.
- POWERUP:
  - `sys_reset_n` stays 0.
  - `lock_s`=0 → PLL_RST. `relock_count` is not incremented here.
  - On expiry → RUN.
- RUN: `sys_reset_n`=1 and `ready`=1. `lock_s`=0 → PLL_RST and `relock_count` increments (saturating).
- Outputs by state:
  - `sys_reset_n`=0 and `ready`=0 in every state except RUN.
  - `pll_rst`=0 outside PLL_RST.
- `sdram_init_start`: exactly one cycle, on the first RUN cycle.
- All outputs are registered, decoded from the next state.
- Reset values: state=PLL_RST, `cnt`=`PLL_RST_CYCLES`−1, `pll_rst`=1, `sys_reset_n`=0, `sdram_init_start`=0, `ready`=0, `relock_count`=0, `timeout_err`=0.
- `timeout_err` and `relock_count` clear only on `rst_n`.

## Timing
- `rst_n` assertion forces every output to its reset value immediately (asynchronous). Deassertion takes effect on the next `refclk` edge. Reset mid-sequence restarts from PLL_RST.
- `pll_locked` rise → `lock_s` rise: 2 cycles. The FSM leaves WAIT_LOCK on the cycle after that.
- Cycle counts:
  - Each state with a counter lasts exactly its parameter value in cycles, when uninterrupted.
  - Minimum time from reset release to `ready`: `PLL_RST_CYCLES` + (sync + 1) + `LOCK_STABLE_CYCLES` + `SDRAM_INIT_CYCLES`.
- Lock loss in RUN:
  - `sys_reset_n`, `ready` fall and `pll_rst` rises together, 3 cycles after `pll_locked` falls (2 sync + 1 register).
  - `relock_count` updates in that same cycle.
- A lock glitch shorter than one `refclk` period may be missed. This is accepted.
- A lock glitch in STABLE restarts the full `LOCK_STABLE_CYCLES` window.

## Structure
- Shared package `plasma_sys_pkg`: FSM state enum (`pll_seq_state_t`) and the default cycle constants above.
- Sub-module `plasma_sync_2ff`: reusable 2-flop synchronizer with async active-low reset to 0. It is used for `pll_locked`.
- Top: FSM, shared counter and diagnostic registers. Target size is about 150–250 lines.

## Test plan
All scenarios use `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `SDRAM_INIT_CYCLES`=10.
1. Reset and clean lock:
   - Stimulus: release `rst_n`; raise `pll_locked` at cycle 10.
   - Required: `pll_rst` high in cycles 0–3. `sys_reset_n`/`ready` rise with a single `sdram_init_start` pulse at cycle 10+3+8+10 = 31.
2. Lock timeout: hold `pll_locked`=0 → `timeout_err`=1 after 4+32 cycles, then a new 4-cycle `pll_rst` pulse. This repeats every 36 cycles.
3. Glitch in STABLE: drop `pll_locked` for 3 cycles midway through STABLE → FSM returns to WAIT_LOCK; `ready` is delayed by a full 8+10 cycles after re-lock; `relock_count`=0.
4. Loss in RUN:
   - Stimulus: from RUN, drop `pll_locked`.
   - Required: 3 cycles later `ready`=0, `sys_reset_n`=0, `pll_rst`=1, `relock_count`=1. Restoring lock returns to RUN with a second `sdram_init_start` pulse.
5. Saturation: force 260 lock losses in RUN → `relock_count`=255.
6. Asynchronous reset in POWERUP: assert `rst_n` mid-state → all outputs take reset values without waiting for a clock edge; the sequence restarts from PLL_RST.
